// File: rtl/io_thread_ctrl_slave_pkg.sv
// Shared definitions for the IO thread-control slave: register offsets, AXI
// response codes, FSM states and the window-decode result record.
package io_thread_ctrl_slave_pkg;

    localparam logic [3:0] THREAD_CTRL_EN      = 4'h0;
    localparam logic [3:0] THREAD_CTRL_RESUME  = 4'h4;
    localparam logic [3:0] THREAD_CTRL_SUSPEND = 4'h8;
    localparam logic [3:0] THREAD_CTRL_ID      = 4'hC;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_PASS = 3'd1,
        ST_RD_PASS = 3'd2,
        ST_LW_ADDR = 3'd3,
        ST_LW_RESP = 3'd4,
        ST_LR_RESP = 3'd5
    } state_t;

    // hit: address inside the window; known: no stray offset bits above [3:0]
    typedef struct packed {
        logic       hit;
        logic       known;
        logic [3:0] off;
    } win_dec_t;

endpackage

// File: rtl/io_thread_ctrl_slave.sv
// AXI4-Lite IO-path slave: terminates the local thread-control window and
// forwards all other traffic to the external master port, one transaction at a time.
module io_thread_ctrl_slave
    import io_thread_ctrl_slave_pkg::*;
#(
    parameter int                    ADDR_WIDTH    = 32,
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    TOTAL_THREADS = 4,
    parameter logic [ADDR_WIDTH-1:0] CTRL_BASE     = 32'h0000_5000,
    parameter logic [ADDR_WIDTH-1:0] CTRL_MASK     = 32'h0000_F000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR_WIDTH-1:0]     s_awaddr,
    input  logic [2:0]                s_awprot,
    input  logic                      s_awvalid,
    output logic                      s_awready,
    input  logic [DATA_WIDTH-1:0]     s_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
    input  logic                      s_wvalid,
    output logic                      s_wready,
    output logic [1:0]                s_bresp,
    output logic                      s_bvalid,
    input  logic                      s_bready,
    input  logic [ADDR_WIDTH-1:0]     s_araddr,
    input  logic [2:0]                s_arprot,
    input  logic                      s_arvalid,
    output logic                      s_arready,
    output logic [DATA_WIDTH-1:0]     s_rdata,
    output logic [1:0]                s_rresp,
    output logic                      s_rvalid,
    input  logic                      s_rready,
    output logic [ADDR_WIDTH-1:0]     m_awaddr,
    output logic [2:0]                m_awprot,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready,
    output logic [ADDR_WIDTH-1:0]     m_araddr,
    output logic [2:0]                m_arprot,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic [1:0]                m_rresp,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    input  logic [TOTAL_THREADS-1:0]  thread_en,
    output logic [TOTAL_THREADS-1:0]  thread_resume_mask,
    output logic [TOTAL_THREADS-1:0]  thread_suspend_mask
);

    localparam logic [ADDR_WIDTH-1:0] LOW_NIBBLE  = {{(ADDR_WIDTH-4){1'b0}}, 4'hF};
    localparam logic [ADDR_WIDTH-1:0] HI_OFF_MASK = ~CTRL_MASK & ~LOW_NIBBLE;

    function automatic win_dec_t win_decode(input logic [ADDR_WIDTH-1:0] addr);
        win_dec_t d;
        d.hit   = (addr & CTRL_MASK) == (CTRL_BASE & CTRL_MASK);
        d.known = (addr & HI_OFF_MASK) == '0;
        d.off   = addr[3:0];
        return d;
    endfunction

    state_t                  state_r, next_s;
    win_dec_t                wdec_r, aw_dec_s, ar_dec_s, wsel_s;
    logic [1:0]              bresp_r, rresp_r;
    logic [DATA_WIDTH-1:0]   rdata_r;
    logic [TOTAL_THREADS-1:0] resume_r, suspend_r, wbits_s;
    logic                    wr_fire_s, rd_fire_s;

    assign aw_dec_s = win_decode(s_awaddr);
    assign ar_dec_s = win_decode(s_araddr);
    assign wsel_s   = (state_r == ST_IDLE) ? aw_dec_s : wdec_r;

    assign m_awaddr = s_awaddr;
    assign m_awprot = s_awprot;
    assign m_wdata  = s_wdata;
    assign m_wstrb  = s_wstrb;
    assign m_araddr = s_araddr;
    assign m_arprot = s_arprot;

    assign s_bresp  = (state_r == ST_WR_PASS) ? m_bresp : bresp_r;
    assign s_rresp  = (state_r == ST_RD_PASS) ? m_rresp : rresp_r;
    assign s_rdata  = (state_r == ST_RD_PASS) ? m_rdata : rdata_r;

    assign thread_resume_mask  = resume_r;
    assign thread_suspend_mask = suspend_r;

    // Thread bits of the write data, each gated by the strobe of its byte lane
    always_comb begin
        wbits_s = '0;
        for (int i = 0; i < TOTAL_THREADS; i++) begin
            wbits_s[i] = s_wdata[i] & s_wstrb[i/8];
        end
    end

    // Next-state and handshake decode; nothing is accepted while reset is held
    always_comb begin
        next_s    = state_r;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        m_awvalid = 1'b0;
        m_wvalid  = 1'b0;
        m_bready  = 1'b0;
        m_arvalid = 1'b0;
        m_rready  = 1'b0;
        wr_fire_s = 1'b0;
        rd_fire_s = 1'b0;
        if (!reset) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (s_awvalid) begin
                        if (aw_dec_s.hit) begin
                            s_awready = 1'b1;
                            if (s_wvalid) begin
                                s_wready  = 1'b1;
                                wr_fire_s = 1'b1;
                                next_s    = ST_LW_RESP;
                            end else begin
                                next_s = ST_LW_ADDR;
                            end
                        end else begin
                            next_s = ST_WR_PASS;
                        end
                    end else if (s_arvalid) begin
                        if (ar_dec_s.hit) begin
                            s_arready = 1'b1;
                            rd_fire_s = 1'b1;
                            next_s    = ST_LR_RESP;
                        end else begin
                            next_s = ST_RD_PASS;
                        end
                    end else begin
                        next_s = ST_IDLE;
                    end
                end
                ST_WR_PASS: begin
                    m_awvalid = s_awvalid;
                    s_awready = m_awready;
                    m_wvalid  = s_wvalid;
                    s_wready  = m_wready;
                    s_bvalid  = m_bvalid;
                    m_bready  = s_bready;
                    if (m_bvalid && s_bready) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_WR_PASS;
                    end
                end
                ST_RD_PASS: begin
                    m_arvalid = s_arvalid;
                    s_arready = m_arready;
                    s_rvalid  = m_rvalid;
                    m_rready  = s_rready;
                    if (m_rvalid && s_rready) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_RD_PASS;
                    end
                end
                ST_LW_ADDR: begin
                    s_wready = s_wvalid;
                    if (s_wvalid) begin
                        wr_fire_s = 1'b1;
                        next_s    = ST_LW_RESP;
                    end else begin
                        next_s = ST_LW_ADDR;
                    end
                end
                ST_LW_RESP: begin
                    s_bvalid = 1'b1;
                    if (s_bready) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_LW_RESP;
                    end
                end
                ST_LR_RESP: begin
                    s_rvalid = 1'b1;
                    if (s_rready) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_LR_RESP;
                    end
                end
                default: next_s = ST_IDLE;
            endcase
        end
    end

    // State, latched write offset, response registers and one-cycle mask pulses
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            wdec_r    <= '0;
            bresp_r   <= AXI_RESP_OKAY;
            rresp_r   <= AXI_RESP_OKAY;
            rdata_r   <= '0;
            resume_r  <= '0;
            suspend_r <= '0;
        end else begin
            state_r   <= next_s;
            resume_r  <= '0;
            suspend_r <= '0;
            if (state_r == ST_IDLE && s_awvalid) begin
                wdec_r <= aw_dec_s;
            end
            if (wr_fire_s) begin
                bresp_r <= AXI_RESP_SLVERR;
                if (wsel_s.known) begin
                    case (wsel_s.off)
                        THREAD_CTRL_RESUME: begin
                            bresp_r  <= AXI_RESP_OKAY;
                            resume_r <= wbits_s;
                        end
                        THREAD_CTRL_SUSPEND: begin
                            bresp_r   <= AXI_RESP_OKAY;
                            suspend_r <= wbits_s;
                        end
                        default: bresp_r <= AXI_RESP_SLVERR;
                    endcase
                end
            end
            if (rd_fire_s) begin
                rdata_r <= '0;
                rresp_r <= AXI_RESP_SLVERR;
                if (ar_dec_s.known) begin
                    case (ar_dec_s.off)
                        THREAD_CTRL_EN: begin
                            rdata_r <= DATA_WIDTH'(thread_en);
                            rresp_r <= AXI_RESP_OKAY;
                        end
                        THREAD_CTRL_ID: begin
                            rdata_r <= DATA_WIDTH'(TOTAL_THREADS);
                            rresp_r <= AXI_RESP_OKAY;
                        end
                        default: rresp_r <= AXI_RESP_SLVERR;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_io_thread_ctrl_slave.sv
// Scoreboard bench for io_thread_ctrl_slave: expected responses are queued when
// a request is driven and popped when the DUT presents its B or R beat.
module tb_io_thread_ctrl_slave;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic [1:0]  m_bresp, m_rresp;
    logic [3:0]  thread_en, thread_resume_mask, thread_suspend_mask;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [3:0]  res;
        logic [3:0]  sus;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    io_thread_ctrl_slave dut (
        .clk(clk), .reset(reset),
        .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .m_awaddr(m_awaddr), .m_awprot(m_awprot), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arprot(m_arprot), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .thread_en(thread_en), .thread_resume_mask(thread_resume_mask),
        .thread_suspend_mask(thread_suspend_mask)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_awaddr = 32'h0; s_awprot = 3'b000; s_awvalid = 1'b0;
        s_wdata = 32'h0; s_wstrb = 4'h0; s_wvalid = 1'b0; s_bready = 1'b0;
        s_araddr = 32'h0; s_arprot = 3'b000; s_arvalid = 1'b0; s_rready = 1'b0;
        m_awready = 1'b0; m_wready = 1'b0; m_bresp = 2'b00; m_bvalid = 1'b0;
        m_arready = 1'b0; m_rdata = 32'h0; m_rresp = 2'b00; m_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        thread_en = 4'b0000;
        tick(); tick();
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 5'b0) begin
            errors++; $display("FAIL reset_s_handshake got=%b exp=00000",
                {s_awready, s_wready, s_bvalid, s_arready, s_rvalid});
        end
        reset = 1'b1;
        tick();
        checks++;
        if ({m_awvalid, m_wvalid, m_arvalid, thread_resume_mask, thread_suspend_mask} !== 11'b0) begin
            errors++; $display("FAIL reset_m_valid_masks got=%b exp=0",
                {m_awvalid, m_wvalid, m_arvalid, thread_resume_mask, thread_suspend_mask});
        end
    endtask

    task automatic test_local_write_same_cycle();
        exp_t e;
        s_awaddr = 32'h5004; s_awvalid = 1'b1;
        s_wdata = 32'h6; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
        #1;
        checks++;
        if ({s_awready, s_wready, m_awvalid} !== 3'b110) begin
            errors++; $display("FAIL wr_same_accept got=%b exp=110", {s_awready, s_wready, m_awvalid});
        end
        exp_q.push_back('{resp: 2'b00, data: 32'h0, res: 4'b0110, sus: 4'b0000});
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({s_bvalid, s_bresp, thread_resume_mask, thread_suspend_mask, m_awvalid} !== {1'b1, e.resp, e.res, e.sus, 1'b0}) begin
            errors++; $display("FAIL wr_same_resp got=%b exp=%b",
                {s_bvalid, s_bresp, thread_resume_mask, thread_suspend_mask, m_awvalid},
                {1'b1, e.resp, e.res, e.sus, 1'b0});
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        checks++;
        if ({s_bvalid, thread_resume_mask} !== 5'b0) begin
            errors++; $display("FAIL wr_same_pulse_end got=%b exp=00000", {s_bvalid, thread_resume_mask});
        end
    endtask

    task automatic test_local_write_delayed_w();
        exp_t e;
        s_awaddr = 32'h5008; s_awvalid = 1'b1; s_wvalid = 1'b0;
        #1;
        checks++;
        if ({s_awready, s_wready} !== 2'b10) begin
            errors++; $display("FAIL wr_delay_aw got=%b exp=10", {s_awready, s_wready});
        end
        tick();
        s_awvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_wready, s_bvalid, thread_suspend_mask} !== 6'b0) begin
                errors++; $display("FAIL wr_delay_wait%0d got=%b exp=0", i, {s_wready, s_bvalid, thread_suspend_mask});
            end
            tick();
        end
        s_wdata = 32'h5; s_wstrb = 4'h1; s_wvalid = 1'b1;
        #1;
        checks++;
        if (s_wready !== 1'b1) begin
            errors++; $display("FAIL wr_delay_wready got=%b exp=1", s_wready);
        end
        exp_q.push_back('{resp: 2'b00, data: 32'h0, res: 4'b0000, sus: 4'b0101});
        tick();
        s_wvalid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({s_bvalid, s_bresp, thread_resume_mask, thread_suspend_mask} !== {1'b1, e.resp, e.res, e.sus}) begin
            errors++; $display("FAIL wr_delay_resp got=%b exp=%b",
                {s_bvalid, s_bresp, thread_resume_mask, thread_suspend_mask}, {1'b1, e.resp, e.res, e.sus});
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
    endtask

    task automatic test_local_read_stall();
        exp_t e;
        thread_en = 4'b1011;
        s_araddr = 32'h5000; s_arvalid = 1'b1; s_rready = 1'b0;
        #1;
        checks++;
        if ({s_arready, m_arvalid} !== 2'b10) begin
            errors++; $display("FAIL rd_accept got=%b exp=10", {s_arready, m_arvalid});
        end
        exp_q.push_back('{resp: 2'b00, data: 32'h0000_000B, res: 4'b0, sus: 4'b0});
        tick();
        s_arvalid = 1'b0;
        thread_en = 4'b0100;
        e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, e.resp, e.data}) begin
                errors++; $display("FAIL rd_stall%0d got=%b/%h exp=1%b/%h", i, {s_rvalid, s_rresp}, s_rdata, e.resp, e.data);
            end
            tick();
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        checks++;
        if (s_rvalid !== 1'b0) begin
            errors++; $display("FAIL rd_done got=%b exp=0", s_rvalid);
        end
    endtask

    task automatic test_pass_write_ar_stall();
        exp_t e;
        thread_en = 4'b0110;
        s_awaddr = 32'h2000; s_awvalid = 1'b1;
        s_wdata = 32'h1234_5678; s_wstrb = 4'hF; s_wvalid = 1'b1;
        s_araddr = 32'h5000; s_arvalid = 1'b1; s_bready = 1'b1; s_rready = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1;
        #1;
        checks++;
        if ({s_awready, s_arready, m_awvalid} !== 3'b000) begin
            errors++; $display("FAIL pass_decode got=%b exp=000", {s_awready, s_arready, m_awvalid});
        end
        tick();
        checks++;
        if ({m_awvalid, m_wvalid, s_awready, s_wready, s_arready, m_arvalid, m_awaddr, m_wdata} !==
            {6'b111100, 32'h2000, 32'h1234_5678}) begin
            errors++; $display("FAIL pass_forward got=%b %h %h exp=111100 00002000 12345678",
                {m_awvalid, m_wvalid, s_awready, s_wready, s_arready, m_arvalid}, m_awaddr, m_wdata);
        end
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({s_arready, s_bvalid, m_arvalid} !== 3'b000) begin
                errors++; $display("FAIL pass_ar_stall%0d got=%b exp=000", i, {s_arready, s_bvalid, m_arvalid});
            end
            tick();
        end
        m_bvalid = 1'b1; m_bresp = 2'b01;
        exp_q.push_back('{resp: 2'b01, data: 32'h0, res: 4'b0, sus: 4'b0});
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({s_bvalid, s_bresp, m_bready, s_arready} !== {1'b1, e.resp, 1'b1, 1'b0}) begin
            errors++; $display("FAIL pass_bresp got=%b exp=%b", {s_bvalid, s_bresp, m_bready, s_arready}, {1'b1, e.resp, 2'b10});
        end
        tick();
        m_bvalid = 1'b0; m_bresp = 2'b00;
        checks++;
        if (s_arready !== 1'b1) begin
            errors++; $display("FAIL pass_ar_release got=%b exp=1", s_arready);
        end
        exp_q.push_back('{resp: 2'b00, data: 32'h0000_0006, res: 4'b0, sus: 4'b0});
        tick();
        s_arvalid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, e.resp, e.data}) begin
            errors++; $display("FAIL pass_ar_after got=%b/%h exp=1%b/%h", {s_rvalid, s_rresp}, s_rdata, e.resp, e.data);
        end
        tick();
        s_rready = 1'b0; s_bready = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
    endtask

    task automatic test_pass_read();
        exp_t e;
        s_araddr = 32'h3000; s_arvalid = 1'b1; s_rready = 1'b1; m_arready = 1'b1;
        tick();
        checks++;
        if ({m_arvalid, s_arready, m_araddr} !== {2'b11, 32'h3000}) begin
            errors++; $display("FAIL pass_rd_ar got=%b %h exp=11 00003000", {m_arvalid, s_arready}, m_araddr);
        end
        tick();
        s_arvalid = 1'b0; m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'hCAFE_F00D; m_rresp = 2'b00;
        exp_q.push_back('{resp: 2'b00, data: 32'hCAFE_F00D, res: 4'b0, sus: 4'b0});
        #1;
        e = exp_q.pop_front();
        checks++;
        if ({s_rvalid, m_rready, s_rresp, s_rdata} !== {2'b11, e.resp, e.data}) begin
            errors++; $display("FAIL pass_rd_r got=%b/%h exp=11%b/%h", {s_rvalid, m_rready, s_rresp}, s_rdata, e.resp, e.data);
        end
        tick();
        m_rvalid = 1'b0; s_rready = 1'b0;
    endtask

    task automatic test_errors();
        logic [31:0] wa [5] = '{32'h5010, 32'h5000, 32'h500C, 32'h5004, 32'h5004};
        logic [31:0] wd [5] = '{32'hF, 32'hF, 32'hF, 32'hF, 32'hFFFF_FFF9};
        logic [3:0]  ws [5] = '{4'hF, 4'hF, 4'hF, 4'h0, 4'hF};
        logic [1:0]  wr [5] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b00};
        logic [3:0]  wm [5] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'b1001};
        logic [31:0] ra [4] = '{32'h5004, 32'h500C, 32'h5020, 32'h5008};
        logic [31:0] rd [4] = '{32'h0, 32'h4, 32'h0, 32'h0};
        logic [1:0]  rr [4] = '{2'b10, 2'b00, 2'b10, 2'b10};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            s_awaddr = wa[i]; s_awvalid = 1'b1;
            s_wdata = wd[i]; s_wstrb = ws[i]; s_wvalid = 1'b1; s_bready = 1'b0;
            exp_q.push_back('{resp: wr[i], data: 32'h0, res: wm[i], sus: 4'h0});
            tick();
            s_awvalid = 1'b0; s_wvalid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({s_bvalid, s_bresp, thread_resume_mask, thread_suspend_mask} !== {1'b1, e.resp, e.res, e.sus}) begin
                errors++; $display("FAIL err_wr%0d got=%b exp=%b", i,
                    {s_bvalid, s_bresp, thread_resume_mask, thread_suspend_mask}, {1'b1, e.resp, e.res, e.sus});
            end
            s_bready = 1'b1;
            tick();
            s_bready = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            s_araddr = ra[i]; s_arvalid = 1'b1; s_rready = 1'b0;
            exp_q.push_back('{resp: rr[i], data: rd[i], res: 4'h0, sus: 4'h0});
            tick();
            s_arvalid = 1'b0;
            e = exp_q.pop_front();
            checks++;
            if ({s_rvalid, s_rresp, s_rdata} !== {1'b1, e.resp, e.data}) begin
                errors++; $display("FAIL err_rd%0d got=%b/%h exp=1%b/%h", i, {s_rvalid, s_rresp}, s_rdata, e.resp, e.data);
            end
            s_rready = 1'b1;
            tick();
            s_rready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_transaction();
        exp_t e;
        s_awaddr = 32'h5004; s_awvalid = 1'b1;
        s_wdata = 32'h1; s_wstrb = 4'hF; s_wvalid = 1'b1; s_bready = 1'b0;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checks++;
        if (s_bvalid !== 1'b1) begin
            errors++; $display("FAIL rst_mid_pre got=%b exp=1", s_bvalid);
        end
        reset = 1'b0;
        tick();
        checks++;
        if ({s_bvalid, thread_resume_mask} !== 5'b0) begin
            errors++; $display("FAIL rst_mid_abort got=%b exp=00000", {s_bvalid, thread_resume_mask});
        end
        reset = 1'b1;
        tick();
        checks++;
        if (s_bvalid !== 1'b0) begin
            errors++; $display("FAIL rst_mid_no_resp got=%b exp=0", s_bvalid);
        end
        s_awaddr = 32'h5008; s_awvalid = 1'b1;
        s_wdata = 32'h2; s_wstrb = 4'hF; s_wvalid = 1'b1;
        exp_q.push_back('{resp: 2'b00, data: 32'h0, res: 4'h0, sus: 4'b0010});
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if ({s_bvalid, s_bresp, thread_resume_mask, thread_suspend_mask} !== {1'b1, e.resp, e.res, e.sus}) begin
            errors++; $display("FAIL rst_mid_new_wr got=%b exp=%b",
                {s_bvalid, s_bresp, thread_resume_mask, thread_suspend_mask}, {1'b1, e.resp, e.res, e.sus});
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_local_write_same_cycle();
        test_local_write_delayed_w();
        test_local_read_stall();
        test_pass_write_ar_stall();
        test_pass_read();
        test_errors();
        test_reset_mid_transaction();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
